regfile_param_2r1w: RTL and testbench

Parametrised, clocked register file with two read ports and one write port. It replaces the fixed 32x32 mode-driven register file in the datapath. It adds synchronous writes with a write enable, registered reads with write-to-read forwarding, and a multi-cycle clear sweep with a busy/done handshake. It sits between decode, which supplies the read addresses, and writeback, which supplies the write port.

---
 rtl/regfile_param_2r1w.sv | 138 +++++++++++++
 tb/tb_regfile_param_2r1w.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param_2r1w.sv
// regfile_param_2r1w: WIDTH x DEPTH register file with two registered read ports, one write port and a clear sweep.
// Optional macro REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
module regfile_param_2r1w #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [WIDTH-1:0]  WriteValue,
    input  logic [ADDR_W-1:0] ReadAddress1,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic [WIDTH-1:0]  ReadValue1,
    output logic [WIDTH-1:0]  ReadValue2,
    input  logic              ClearReq,
    output logic              Busy,
    output logic              ClearDone
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  rd1_q, rd1_d;
    logic [WIDTH-1:0]  rd2_q, rd2_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];

    logic busy;
    logic last_idx;
    logic wr_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    // Read priority: out of range, hardwired zero, clear forwarding, write forwarding, storage.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored,
        input logic              sweeping,
        input logic [ADDR_W-1:0] sweep_idx,
        input logic              wr_accept,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [WIDTH-1:0]  wr_val
    );
        if (!in_range(a))                      return '0;
        if (ZERO_REG && a == '0)               return '0;
        if (sweeping && a == sweep_idx)        return '0;
        if (wr_accept && a == wr_addr)         return wr_val;
        return stored;
    endfunction

    assign busy     = (state_q == ST_CLEAR);
    assign last_idx = (int'(idx_q) == DEPTH - 1);
    assign wr_ok    = WriteEnable && !busy && in_range(WriteAddress)
                      && !(ZERO_REG && WriteAddress == '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        mem_d   = mem_q;

        rd1_d = read_port(ReadAddress1, mem_q[ReadAddress1], busy, idx_q,
                          wr_ok, WriteAddress, WriteValue);
        rd2_d = read_port(ReadAddress2, mem_q[ReadAddress2], busy, idx_q,
                          wr_ok, WriteAddress, WriteValue);

        if (wr_ok) begin
            mem_d[WriteAddress] = WriteValue;
        end

        // A write accepted alongside ClearReq commits now and is wiped later by the sweep.
        case (state_q)
            ST_IDLE: begin
                if (ClearReq) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                mem_d[idx_q] = '0;
                if (last_idx) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign ReadValue1 = rd1_q;
    assign ReadValue2 = rd2_q;
    assign Busy       = busy;
    assign ClearDone  = done_q;

endmodule

// File: tb/tb_regfile_param_2r1w.sv
// Testbench for regfile_param_2r1w: a DEPTH=32 and a DEPTH=24 instance driven in lockstep,
// checked against a sweep-countdown reference model, a vector table and hand-written sweep/reset sequences.
module tb_regfile_param_2r1w;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZeroRegEn = 1'b1;
`else
    localparam bit ZeroRegEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] writeValue;
    logic [4:0]  readAddress1;
    logic [4:0]  readAddress2;
    logic        clearReq;

    logic [31:0] rv1A, rv2A, rv1B, rv2B;
    logic        busyA, doneA, busyB, doneB;

    int vectors = 0;
    int miscompares = 0;

    regfile_param_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dutA (
        .clk(clk), .reset(reset),
        .WriteEnable(writeEnable), .WriteAddress(writeAddress), .WriteValue(writeValue),
        .ReadAddress1(readAddress1), .ReadAddress2(readAddress2),
        .ReadValue1(rv1A), .ReadValue2(rv2A),
        .ClearReq(clearReq), .Busy(busyA), .ClearDone(doneA)
    );

    regfile_param_2r1w #(.WIDTH(32), .DEPTH(24), .ADDR_W(5)) dutB (
        .clk(clk), .reset(reset),
        .WriteEnable(writeEnable), .WriteAddress(writeAddress), .WriteValue(writeValue),
        .ReadAddress1(readAddress1), .ReadAddress2(readAddress2),
        .ReadValue1(rv1B), .ReadValue2(rv2B),
        .ClearReq(clearReq), .Busy(busyB), .ClearDone(doneB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: model 0 mirrors dutA (DEPTH 32), model 1 mirrors dutB (DEPTH 24).
    // A sweep is tracked as a count of remaining cycles; the entry being cleared is depth - remaining.
    int          depthOf [2] = '{32, 24};
    logic [31:0] mMem [2][32];
    int          mLeft [2];
    bit          mDone [2];
    logic [31:0] mRv1 [2];
    logic [31:0] mRv2 [2];

    task automatic modelReset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 32; i++) mMem[m][i] = 32'h0;
            mLeft[m] = 0;
            mDone[m] = 1'b0;
            mRv1[m]  = 32'h0;
            mRv2[m]  = 32'h0;
        end
    endtask

    function automatic logic [31:0] expectRead(int m, int a, bit sweeping, int cur, bit wrOk);
        if (a >= depthOf[m])             return 32'h0;
        if (ZeroRegEn && a == 0)         return 32'h0;
        if (sweeping && a == cur)        return 32'h0;
        if (wrOk && a == int'(writeAddress)) return writeValue;
        return mMem[m][a];
    endfunction

    task automatic modelStep();
        for (int m = 0; m < 2; m++) begin
            bit sweeping;
            int cur;
            bit wrOk;
            sweeping = mLeft[m] > 0;
            cur      = depthOf[m] - mLeft[m];
            wrOk     = writeEnable && !sweeping && int'(writeAddress) < depthOf[m]
                       && !(ZeroRegEn && writeAddress == 5'd0);
            mRv1[m]  = expectRead(m, int'(readAddress1), sweeping, cur, wrOk);
            mRv2[m]  = expectRead(m, int'(readAddress2), sweeping, cur, wrOk);
            if (wrOk) mMem[m][writeAddress] = writeValue;
            if (sweeping) mMem[m][cur] = 32'h0;
            mDone[m] = sweeping && mLeft[m] == 1;
            if (sweeping) mLeft[m] = mLeft[m] - 1;
            else if (clearReq) mLeft[m] = depthOf[m];
        end
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, advances the model and the clock, and leaves time 1 after the edge.
    task automatic applyStimulus(bit we, int wa, logic [31:0] wv, int ra1, int ra2, bit clr);
        writeEnable  = we;
        writeAddress = 5'(wa);
        writeValue   = wv;
        readAddress1 = 5'(ra1);
        readAddress2 = 5'(ra2);
        clearReq     = clr;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(string tag);
        cmp({tag, ".A.rv1"},  rv1A, mRv1[0]);
        cmp({tag, ".A.rv2"},  rv2A, mRv2[0]);
        cmp({tag, ".A.busy"}, 32'(busyA), 32'(mLeft[0] > 0));
        cmp({tag, ".A.done"}, 32'(doneA), 32'(mDone[0]));
        cmp({tag, ".B.rv1"},  rv1B, mRv1[1]);
        cmp({tag, ".B.rv2"},  rv2B, mRv2[1]);
        cmp({tag, ".B.busy"}, 32'(busyB), 32'(mLeft[1] > 0));
        cmp({tag, ".B.done"}, 32'(doneB), 32'(mDone[1]));
    endtask

    typedef struct {
        bit          we;
        int          wa;
        logic [31:0] wv;
        int          ra1;
        int          ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t table_v [8];

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish within its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        logic [31:0] zeroFf;
        int busyCntA, busyCntB, doneCntA, doneCntB;

        zeroFf = ZeroRegEn ? 32'h0 : 32'hFFFF_FFFF;
        // Expectations below are for dutA (DEPTH 32).
        table_v[0] = '{1'b1,  3, 32'h1234_5678,  0,  0, 32'h0,         32'h0};
        table_v[1] = '{1'b1, 31, 32'hDEAD_BEEF,  3, 31, 32'h1234_5678, 32'hDEAD_BEEF};
        table_v[2] = '{1'b0,  0, 32'h0,          3, 31, 32'h1234_5678, 32'hDEAD_BEEF};
        table_v[3] = '{1'b1,  7, 32'hA5A5_A5A5,  7,  7, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        table_v[4] = '{1'b1,  0, 32'hFFFF_FFFF,  0,  0, zeroFf,        zeroFf};
        table_v[5] = '{1'b0,  0, 32'h0,          0,  7, zeroFf,        32'hA5A5_A5A5};
        table_v[6] = '{1'b1, 30, 32'h0000_0055, 30,  3, 32'h0000_0055, 32'h1234_5678};
        table_v[7] = '{1'b0,  0, 32'h0,         30, 30, 32'h0000_0055, 32'h0000_0055};

        writeEnable = 1'b0; writeAddress = '0; writeValue = '0;
        readAddress1 = '0; readAddress2 = '0; clearReq = 1'b0;
        reset = 1'b1;
        modelReset();
        #13;
        checkOutput("reset");
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] vector table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(table_v[i].we, table_v[i].wa, table_v[i].wv,
                          table_v[i].ra1, table_v[i].ra2, 1'b0);
            checkOutput($sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.tbl1", i), rv1A, table_v[i].exp1);
            cmp($sformatf("vec%0d.tbl2", i), rv2A, table_v[i].exp2);
            if (i == 2) cmp("d24.addr31", rv2B, 32'h0);
            if (i >= 6) cmp($sformatf("d24.addr30.%0d", i), rv1B, 32'h0);
        end

        $display("[TB] clear sweep");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, i, 32'(i), i, 0, 1'b0);
            checkOutput("fill");
        end
        applyStimulus(1'b1, 9, 32'h77, 9, 9, 1'b1);
        checkOutput("clrStart");
        cmp("clrStart.fwd", rv1A, ZeroRegEn ? 32'h77 : 32'h77);
        busyCntA = int'(busyA); busyCntB = int'(busyB);
        doneCntA = 0; doneCntB = 0;
        for (int k = 0; k < 45; k++) begin
            applyStimulus(k == 3, 5, 32'h1, k % 32, (k + 1) % 32, 1'b0);
            checkOutput("sweep");
            if (k < 32) cmp($sformatf("sweep.idxRead%0d", k), rv1A, 32'h0);
            busyCntA += int'(busyA); busyCntB += int'(busyB);
            doneCntA += int'(doneA); doneCntB += int'(doneB);
        end
        cmp("sweep.busyCyclesA", 32'(busyCntA), 32'd32);
        cmp("sweep.busyCyclesB", 32'(busyCntB), 32'd24);
        cmp("sweep.donePulsesA", 32'(doneCntA), 32'd1);
        cmp("sweep.donePulsesB", 32'(doneCntB), 32'd1);
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 0, 32'h0, i, (i + 16) % 32, 1'b0);
            checkOutput("afterClr");
            cmp($sformatf("afterClr.a%0d", i), rv1A, 32'h0);
        end

        $display("[TB] reset mid-sweep");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, i, 32'hF0 + 32'(i), 0, 0, 1'b0);
            checkOutput("fill2");
        end
        applyStimulus(1'b0, 0, 32'h0, 0, 0, 1'b1);
        checkOutput("clrStart2");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 0, 32'h0, k, 7, 1'b0);
            checkOutput("sweep2");
        end
        reset = 1'b1;
        modelReset();
        #1;
        checkOutput("midReset");
        cmp("midReset.busyA", 32'(busyA), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        doneCntA = 0; doneCntB = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, 0, 32'h0, i % 32, (i + 5) % 32, 1'b0);
            checkOutput("postReset");
            doneCntA += int'(doneA); doneCntB += int'(doneB);
        end
        cmp("postReset.doneA", 32'(doneCntA), 32'd0);
        cmp("postReset.doneB", 32'(doneCntB), 32'd0);

        $display("[TB] random");
        for (int n = 0; n < 400; n++) begin
            int wa;
            int ra1;
            wa  = int'($urandom_range(31, 0));
            ra1 = ($urandom_range(3, 0) == 0) ? wa : int'($urandom_range(31, 0));
            applyStimulus($urandom_range(1, 0) == 1, wa, $urandom, ra1,
                          int'($urandom_range(31, 0)), $urandom_range(49, 0) == 0);
            checkOutput("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
